// File: rtl/sw_pkg.sv
// Shared defaults for the switch conditioning slice: channel count,
// debounce lengths, per-channel debounce state encoding and counter width rule.
package sw_pkg;

    localparam int unsigned N_SW_DEF     = 4;
    localparam int unsigned DEBOUNCE_DEF = 250000;
    localparam int unsigned DEBOUNCE_SIM = 4;

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_COUNTING = 1'b1
    } sw_state_t;

    // Counter must be able to hold DEBOUNCE_CYCLES itself.
    function automatic int unsigned cnt_width(int unsigned d);
        return $clog2(d + 1);
    endfunction

endpackage

// File: rtl/sw_conditioner_if.sv
// Switch bundle between the raw switch source (master) and the conditioner (slave).
interface sw_conditioner_if
    import sw_pkg::*;
#(
    parameter int unsigned N_SW = N_SW_DEF
) ();

    logic [N_SW-1:0]         sw_raw;
    logic [N_SW-1:0]         sw_clean;
    logic [N_SW-1:0]         sw_rise;
    logic                    sw_onehot;
    logic [$clog2(N_SW)-1:0] sw_code;

    modport master (
        output sw_raw,
        input  sw_clean, sw_rise, sw_onehot, sw_code
    );

    modport slave (
        input  sw_raw,
        output sw_clean, sw_rise, sw_onehot, sw_code
    );

endinterface

// File: rtl/sw_debounce_ch.sv
// One switch channel: 2-flop synchronizer, bounded debounce counter and clean level.
// rise_raw flags the edge at which clean is about to go 0->1.
module sw_debounce_ch
    import sw_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic clean,
    output logic rise_raw
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic          done;
    sw_state_t     state;

    assign done     = (32'(cnt) + 32'd1) >= DEBOUNCE_CYCLES;
    assign rise_raw = sync2 & ~clean & done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            clean <= 1'b0;
            state <= ST_STABLE;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            case (state)
                ST_STABLE: begin
                    if (sync2 != clean) begin
                        // A one-cycle debounce accepts on the first mismatch.
                        if (done) begin
                            clean <= ~clean;
                        end else begin
                            cnt   <= CW'(1);
                            state <= ST_COUNTING;
                        end
                    end
                end
                ST_COUNTING: begin
                    if (sync2 == clean) begin
                        cnt   <= '0;
                        state <= ST_STABLE;
                    end else if (done) begin
                        clean <= ~clean;
                        cnt   <= '0;
                        state <= ST_STABLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= ST_STABLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/sw_conditioner.sv
// Switch conditioner top: per-channel debounce, rise strobes and one-hot decode.
// Define SW_ONEHOT_GATE_EN to suppress rise strobes unless the clean levels are one-hot.
module sw_conditioner
    import sw_pkg::*;
#(
    parameter int unsigned N_SW            = N_SW_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
    input  logic           clk,
    input  logic           reset,
    sw_conditioner_if.slave sw
);

    localparam int unsigned CODE_W = $clog2(N_SW);

    logic [N_SW-1:0]   clean_v;
    logic [N_SW-1:0]   rise_raw_v;
    logic [N_SW-1:0]   rise_q;
    logic              onehot;
    logic [CODE_W-1:0] code;

    for (genvar g = 0; g < N_SW; g++) begin : g_ch
        sw_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .raw     (sw.sw_raw[g]),
            .clean   (clean_v[g]),
            .rise_raw(rise_raw_v[g])
        );
    end

    assign onehot = (clean_v != '0) && ((clean_v & (clean_v - N_SW'(1))) == '0);

    always_comb begin
        code = '0;
        for (int unsigned i = 0; i < N_SW; i++) begin
            if (onehot && clean_v[i]) begin
                code = CODE_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rise_q <= '0;
        end else begin
            rise_q <= rise_raw_v;
        end
    end

    assign sw.sw_clean  = clean_v;
    assign sw.sw_onehot = onehot;
    assign sw.sw_code   = code;

`ifdef SW_ONEHOT_GATE_EN
    // rise_q lines up with the cycle in which the updated clean levels are visible,
    // so the one-hot decode of those levels masks it directly.
    assign sw.sw_rise = rise_q & {N_SW{onehot}};
`else
    assign sw.sw_rise = rise_q;
`endif

endmodule

// File: doc/sw_conditioner.md
# sw_conditioner

Input conditioning stage for the lab switch-driven state machines. Takes raw, asynchronous slide/push switch levels, synchronizes and debounces each channel, and presents clean levels, single-cycle rising-edge strobes and a one-hot "exactly one switch active" decode. Sits directly upstream of the FSM: its clean outputs drive the FSM's SW1..SW4 inputs, and the one-hot flag replaces the FSM's hand-written `SWx & !SWy ...` exclusivity terms.

## Interface
- `N_SW`, default 4: number of switch channels; minimum 2.
- `DEBOUNCE_CYCLES`, default 250000: consecutive stable cycles required before a level is accepted; minimum 1. Use 4 in simulation.
- `clk`  input  1  system clock, rising-edge.
- `reset`  input  1  asynchronous, active-low reset. One clock; no other clock domain.
- `sw_raw`  input  N_SW  raw switch levels, asynchronous to `clk`.
- `sw_clean`  output  N_SW  debounced levels.
- `sw_rise`  output  N_SW  one-cycle pulse per channel on each accepted 0->1 transition.
- `sw_onehot`  output  1  high when exactly one `sw_clean` bit is high.
- `sw_code`  output  $clog2(N_SW)  index of the single high `sw_clean` bit when `sw_onehot`=1, else 0.

## Operation
- Per channel: 2-flop synchronizer (`sync1`, `sync2`), debounce counter `cnt`, width $clog2(DEBOUNCE_CYCLES+1), and `clean` register.
- Per-channel states: STABLE (`sync2`==`clean`, `cnt`=0) and COUNTING (`sync2`!=`clean`).
- STABLE -> COUNTING: `sync2` differs from `clean`; `cnt` becomes 1.
- COUNTING: on each edge with `sync2`!=`clean`, `cnt` increments; when the increment would reach DEBOUNCE_CYCLES, `clean` toggles, `cnt` clears, back to STABLE.
- COUNTING -> STABLE without toggle: `sync2` returns to `clean` before the count completes; `cnt` clears. A glitch shorter than DEBOUNCE_CYCLES never reaches `sw_clean`.
- `cnt` never wraps; it is bounded by DEBOUNCE_CYCLES.
- `sw_rise[i]` is registered; it is high for exactly the one cycle in which `sw_clean[i]` first reads 1. No strobe on 1->0.
- `sw_onehot` and `sw_code` are combinational from `sw_clean`. With zero or multiple bits high: `sw_onehot`=0, `sw_code`=0.
- Simultaneous acceptance on several channels in the same cycle is legal; every affected `sw_rise` bit pulses together (subject to Configuration).
- Reset (asserted at any time, including mid-count) asynchronously clears `sync1`, `sync2`, `cnt`, `sw_clean` and `sw_rise` to 0. A switch held high through reset is re-accepted as a fresh rise after release.

## Timing
- Reset values: `sw_clean`=0, `sw_rise`=0, `sw_onehot`=0, `sw_code`=0.
- A raw change sampled at edge k appears in `sync2` at edge k+1. `sw_clean` toggles at edge k+1+DEBOUNCE_CYCLES, provided the level is held throughout. `sw_rise` is high during the cycle following that edge.
- `sw_onehot` and `sw_code` settle in the same cycle as `sw_clean`.
- Downstream FSM samples on the same `clk`. No handshake; strobes are not held.

## Configuration
- `SW_ONEHOT_GATE_EN` defined: `sw_rise` bits are masked unless the updated `sw_clean` is one-hot. A second switch accepted while another is high produces no strobe. Two channels accepted in the same cycle produce no strobe.
- Undefined: `sw_rise` is per channel and independent of the other channels.
- `sw_clean`, `sw_onehot` and `sw_code` are identical in both builds.

## Structure
- Shared package `sw_pkg` holds:
  - the `N_SW` default;
  - the `DEBOUNCE_CYCLES` default;
  - the simulation value `DEBOUNCE_SIM` = 4;
  - the counter-width localparam rule.
- Natural sub-module `sw_debounce_ch`: synchronizer, counter and clean register for one channel, with ports `clk`, `reset`, `raw`, `clean`, `rise_raw`. It is instantiated N_SW times in a generate loop.
- The top level adds the one-hot decode, the optional gating and the `sw_rise` output register.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and N_SW=4.
- Clean press: `sw_raw`=0001 at edge 0 -> `sw_clean`=0001 after edge 5; `sw_rise`=0001 for one cycle; `sw_onehot`=1; `sw_code`=0.
- Glitch rejection: `sw_raw`[2] high for 3 cycles then low -> `sw_clean` stays 0000; no `sw_rise`.
- Release: from `sw_clean`=0100, drop raw -> `sw_clean`=0000 after edge k+5; no `sw_rise`; `sw_onehot`=0; `sw_code`=0.
- Multiple switches: hold 0010, then add bit 3 -> final `sw_clean`=1010, `sw_onehot`=0, `sw_code`=0. The second `sw_rise` pulse (1000) appears only without `SW_ONEHOT_GATE_EN`; with it, there is no pulse.
- Reset mid-count: assert `reset`=0 at `cnt`=3 -> all outputs 0 immediately. Deassert with raw still 0001 -> full 4-cycle re-debounce followed by a `sw_rise` pulse.
- Simultaneous: raw 0000->0011 in one cycle -> both bits clean on the same edge. Without the macro, `sw_rise`=0011 for one cycle; with it, 0000.
